// File: rtl/gnr_node_pkg.sv
// Shared types and helpers for the gene-regulatory-network node.
// Holds the node FSM state type and a min-1 clog2 for counter sizing.
package gnr_node_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } node_st_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/gnr_pace_div.sv
// SLOW_DIV pulse divider for the slow trajectory copy.
// Ports: clk, rst (async active-low), load (preset to last slot), tick in, fire out.
module gnr_pace_div
  import gnr_node_pkg::*;
#(
  parameter int SLOW_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic fire
);

  localparam int DW = clog2_min1(SLOW_DIV);
  localparam logic [DW-1:0] MAX = DW'(SLOW_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          hit;

  assign hit  = (div_cnt == MAX);
  assign fire = tick & hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (load) begin
      div_cnt <= MAX;
    end else if (tick) begin
      div_cnt <= hit ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gnr_node_cycle.sv
// GRN node with slow (s0) and fast (s1) state copies and attractor detection.
// Ports: clk, rst (async active-low), reset_nos, start_s0/s1, init_state,
// rhoa_s0/s1 in; s0, s1, rock_s0/s1, found, step_cnt out.
// Macro GNR_NODE_STEP_CNT_EN builds the saturating fast-step counter.
module gnr_node_cycle
  import gnr_node_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int SLOW_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic             start_s0,
  input  logic             start_s1,
  input  logic [WIDTH-1:0] init_state,
  input  logic [WIDTH-1:0] rhoa_s0,
  input  logic [WIDTH-1:0] rhoa_s1,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] rock_s0,
  output logic [WIDTH-1:0] rock_s1,
  output logic             found,
  output logic [CNT_W-1:0] step_cnt
);

  node_st_t         state;
  logic             fire;
  logic [WIDTH-1:0] nxt_s0;
  logic [WIDTH-1:0] nxt_s1;

  // a reseed owns the cycle, so the divider must not also advance
  gnr_pace_div #(
    .SLOW_DIV(SLOW_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .load(reset_nos),
    .tick(start_s0 & ~reset_nos),
    .fire(fire)
  );

  assign nxt_s0  = fire ? rhoa_s0 : s0;
  assign nxt_s1  = start_s1 ? rhoa_s1 : s1;
  assign rock_s0 = s0;
  assign rock_s1 = s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0    <= '0;
      s1    <= '0;
      found <= 1'b0;
      state <= ST_IDLE;
    end else if (reset_nos) begin
      s0    <= init_state;
      s1    <= init_state;
      found <= 1'b0;
      state <= ST_RUN;
    end else begin
      if (fire) s0 <= rhoa_s0;
      if (start_s1) s1 <= rhoa_s1;
      unique case (state)
        ST_RUN: begin
          // convergence is only judged on fast steps
          if (start_s1 && (nxt_s0 == nxt_s1)) begin
            state <= ST_DONE;
            found <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GNR_NODE_STEP_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (reset_nos) begin
      cnt <= '0;
    end else if (state == ST_RUN && start_s1 && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step_cnt = cnt;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_gnr_node_cycle.sv
// Directed self-checking bench for gnr_node_cycle.
// WIDTH=3, SLOW_DIV=2, CNT_W=2; counter expectations follow GNR_NODE_STEP_CNT_EN.
module tb_gnr_node_cycle;

  localparam int W = 3;
  localparam int CW = 2;

`ifdef GNR_NODE_STEP_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reset_nos = 1'b0;
  logic          start_s0 = 1'b0;
  logic          start_s1 = 1'b0;
  logic [W-1:0]  init_state = '0;
  logic [W-1:0]  rhoa_s0 = '0;
  logic [W-1:0]  rhoa_s1 = '0;
  logic [W-1:0]  s0;
  logic [W-1:0]  s1;
  logic [W-1:0]  rock_s0;
  logic [W-1:0]  rock_s1;
  logic          found;
  logic [CW-1:0] step_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gnr_node_cycle #(
    .WIDTH   (W),
    .SLOW_DIV(2),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reset_nos (reset_nos),
    .start_s0  (start_s0),
    .start_s1  (start_s1),
    .init_state(init_state),
    .rhoa_s0   (rhoa_s0),
    .rhoa_s1   (rhoa_s1),
    .s0        (s0),
    .s1        (s1),
    .rock_s0   (rock_s0),
    .rock_s1   (rock_s1),
    .found     (found),
    .step_cnt  (step_cnt)
  );

  // observed bundle: s0, s1, rock_s0, rock_s1, found, step_cnt
  logic [4*W+CW:0] obs;
  assign obs = {s0, s1, rock_s0, rock_s1, found, step_cnt};

  function automatic logic [4*W+CW:0] exp_v(
    input logic [W-1:0] e0, input logic [W-1:0] e1,
    input logic ef, input int n
  );
    logic [CW-1:0] c;
    c = CNT_ON ? CW'(n) : '0;
    return {e0, e1, e0, e1, ef, c};
  endfunction

  task automatic clear_in();
    reset_nos = 1'b0;
    start_s0  = 1'b0;
    start_s1  = 1'b0;
  endtask

  // one clock with the current inputs, then sample 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic reseed(input logic [W-1:0] v);
    init_state = v;
    reset_nos  = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [4*W+CW:0] e;
    rst = 1'b0;
    #3;
    e = exp_v(3'd0, 3'd0, 1'b0, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", obs, e);
    end
    @(negedge clk);
    rst = 1'b1;
    // idle: first start_s0 only advances the divider, s1 tracks, no found
    start_s0 = 1'b1; rhoa_s0 = 3'd6;
    start_s1 = 1'b1; rhoa_s1 = 3'd0;
    cyc();
    e = exp_v(3'd0, 3'd0, 1'b0, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL idle_no_found got %h exp %h", obs, e);
    end
    start_s1 = 1'b1; rhoa_s1 = 3'd4;
    cyc();
    e = exp_v(3'd0, 3'd4, 1'b0, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL idle_s1_update got %h exp %h", obs, e);
    end
  endtask

  task automatic test_slow_div();
    logic [W-1:0] r1 [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [W-1:0] x1 [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
    logic [W-1:0] r2 [4] = '{3'd6, 3'd3, 3'd5, 3'd2};
    logic [W-1:0] x2 [4] = '{3'd6, 3'd6, 3'd5, 3'd5};
    logic [4*W+CW:0] e;
    reseed(3'd1);
    e = exp_v(3'd1, 3'd1, 1'b0, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reseed_1 got %h exp %h", obs, e);
    end
    for (int i = 0; i < 4; i++) begin
      start_s0 = 1'b1; rhoa_s0 = r1[i];
      cyc();
      n_checks++;
      if (s0 !== x1[i]) begin
        n_fail++;
        $display("FAIL slow_a%0d got %0d exp %0d", i, s0, x1[i]);
      end
    end
    reseed(3'd1);
    for (int i = 0; i < 4; i++) begin
      start_s0 = 1'b1; rhoa_s0 = r2[i];
      cyc();
      n_checks++;
      if (s0 !== x2[i] || s1 !== 3'd1) begin
        n_fail++;
        $display("FAIL slow_b%0d got %0d/%0d exp %0d/1", i, s0, s1, x2[i]);
      end
    end
  endtask

  task automatic test_fast_and_s0_match();
    logic [4*W+CW:0] e;
    reseed(3'd5);
    start_s1 = 1'b1; rhoa_s1 = 3'd2; rhoa_s0 = 3'd7;
    cyc();
    e = exp_v(3'd5, 3'd2, 1'b0, 1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL fast_step got %h exp %h", obs, e);
    end
    // s0 catches up on its own: no compare, no found
    start_s0 = 1'b1; rhoa_s0 = 3'd2;
    cyc();
    e = exp_v(3'd2, 3'd2, 1'b0, 1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL s0_only_match got %h exp %h", obs, e);
    end
    start_s1 = 1'b1; rhoa_s1 = 3'd2;
    cyc();
    e = exp_v(3'd2, 3'd2, 1'b1, 2);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL fast_converge got %h exp %h", obs, e);
    end
  endtask

  task automatic test_both_starts();
    logic [4*W+CW:0] e;
    reseed(3'd1);
    start_s0 = 1'b1; rhoa_s0 = 3'd4;
    start_s1 = 1'b1; rhoa_s1 = 3'd4;
    cyc();
    e = exp_v(3'd4, 3'd4, 1'b1, 1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL both_converge got %h exp %h", obs, e);
    end
    // done: s1 keeps following, found and counter hold
    start_s1 = 1'b1; rhoa_s1 = 3'd6;
    cyc();
    e = exp_v(3'd4, 3'd6, 1'b1, 1);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL done_hold got %h exp %h", obs, e);
    end
  endtask

  task automatic test_reseed_in_done();
    logic [4*W+CW:0] e;
    init_state = 3'd3;
    reset_nos = 1'b1;
    start_s0 = 1'b1; rhoa_s0 = 3'd7;
    start_s1 = 1'b1; rhoa_s1 = 3'd3;
    cyc();
    e = exp_v(3'd3, 3'd3, 1'b0, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reseed_done got %h exp %h", obs, e);
    end
    cyc();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reseed_quiet got %h exp %h", obs, e);
    end
  endtask

  task automatic test_saturate();
    int xc [5] = '{1, 2, 3, 3, 3};
    logic [4*W+CW:0] e;
    reseed(3'd0);
    for (int i = 0; i < 5; i++) begin
      start_s1 = 1'b1; rhoa_s1 = W'(i + 1);
      cyc();
      e = exp_v(3'd0, W'(i + 1), 1'b0, xc[i]);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL sat_%0d got %h exp %h", i, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4*W+CW:0] e;
    reseed(3'd6);
    start_s1 = 1'b1; rhoa_s1 = 3'd2;
    cyc();
    #2;
    rst = 1'b0;
    #1;
    e = exp_v(3'd0, 3'd0, 1'b0, 0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL async_rst got %h exp %h", obs, e);
    end
    @(negedge clk);
    rst = 1'b1;
    // back in idle: matching fast step must not flag
    start_s1 = 1'b1; rhoa_s1 = 3'd0;
    cyc();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL post_rst_idle got %h exp %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_slow_div();
    test_fast_and_s0_match();
    test_both_starts();
    test_reseed_in_done();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
